// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM.
// Sequences fetch (IF), decode (ID), execute (EX), memory (MEM) and
// write-back (WB). Memory uses a req/ack handshake with a bounded wait.
// A timeout sets the sticky bus_err flag. An unknown instruction sets the
// sticky illegal flag. Either one parks the FSM in HALT until reset.
//
// Optional feature (macro MC_CTRL_PERF_EN): adds the instr_cnt and
// stall_cnt performance counters.
//
// Ports:
//   clk, reset (async, active low)
//   opcode, funct        IR decode fields
//   zero                 ALU equal flag (used in EX by beq)
//   mem_ack              memory completes the current request
//   pc_we, pc_src        PC load enable / next-PC select
//   ir_we                IR load
//   mem_req, mem_we, mem_ifetch   memory request qualifiers
//   reg_we, reg_dst, wd_src       register-file write controls
//   alu_op, alu_src_imm, ext_sign ALU controls
//   bus_err, illegal     sticky error flags
//   state                current FSM state (debug)
//   instr_cnt, stall_cnt performance counters (MC_CTRL_PERF_EN only)
module mc_ctrl #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       ir_we,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_ifetch,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_src,
    output logic [2:0] alu_op,
    output logic       alu_src_imm,
    output logic       ext_sign,
    output logic       bus_err,
    output logic       illegal,
    output logic [2:0] state
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [31:0] instr_cnt,
    output logic [31:0] stall_cnt
`endif
);
    typedef enum logic [2:0] {
        S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd7
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02, OP_JAL = 6'h03;
    localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_JR = 6'h08;

    state_t           st;
    logic [CNT_W-1:0] cnt;

    logic is_addu, is_subu, is_jr, is_rtype, is_ori, is_lui, is_lw, is_sw;
    logic is_beq, is_j, is_jal, is_jump, is_legal;

    always_comb begin
        is_addu  = (opcode == OP_R) && (funct == FN_ADDU);
        is_subu  = (opcode == OP_R) && (funct == FN_SUBU);
        is_jr    = (opcode == OP_R) && (funct == FN_JR);
        is_rtype = is_addu | is_subu;   // jr finishes in ID, so only these reach EX/WB
        is_ori   = (opcode == OP_ORI);
        is_lui   = (opcode == OP_LUI);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_beq   = (opcode == OP_BEQ);
        is_j     = (opcode == OP_J);
        is_jal   = (opcode == OP_JAL);
        is_jump  = is_j | is_jal | is_jr;
        is_legal = is_rtype | is_jump | is_ori | is_lui | is_lw | is_sw | is_beq;
    end

    // Datapath enables are decoded from the current state. They are forced
    // low while reset is asserted, so nothing writes during an abort.
    always_comb begin
        pc_we = 1'b0; pc_src = 2'd0; ir_we = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        mem_ifetch = 1'b0; reg_we = 1'b0; reg_dst = 2'd0; wd_src = 2'd0;
        alu_op = 3'd0; alu_src_imm = 1'b0; ext_sign = 1'b0;
        case (st)
            S_IF: begin
                mem_req    = 1'b1;
                mem_ifetch = 1'b1;
                ir_we      = mem_ack;
                pc_we      = mem_ack;
            end
            S_ID: begin
                if (is_j || is_jal) begin
                    pc_we = 1'b1; pc_src = 2'd2;
                end
                if (is_jal) begin
                    reg_we = 1'b1; reg_dst = 2'd2; wd_src = 2'd2;
                end
                if (is_jr) begin
                    pc_we = 1'b1; pc_src = 2'd3;
                end
            end
            S_EX: begin
                if (is_subu) alu_op = 3'd1;
                if (is_ori) begin
                    alu_op = 3'd2; alu_src_imm = 1'b1;
                end
                if (is_lui) begin
                    alu_op = 3'd3; alu_src_imm = 1'b1;
                end
                if (is_lw || is_sw) begin
                    alu_src_imm = 1'b1; ext_sign = 1'b1;
                end
                if (is_beq) begin
                    alu_op = 3'd1; pc_we = zero; pc_src = 2'd1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_sw;
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = is_rtype ? 2'd1 : 2'd0;
                wd_src  = is_lw ? 2'd1 : 2'd0;
            end
            default: ;
        endcase
        if (!reset) begin
            pc_we = 1'b0; pc_src = 2'd0; ir_we = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
            mem_ifetch = 1'b0; reg_we = 1'b0; reg_dst = 2'd0; wd_src = 2'd0;
            alu_op = 3'd0; alu_src_imm = 1'b0; ext_sign = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st      <= S_IF;
            cnt     <= '0;
            bus_err <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (st)
                S_IF, S_MEM: begin
                    // An ack in the limit cycle completes normally.
                    if (mem_ack) begin
                        cnt <= '0;
                        if (st == S_IF)  st <= S_ID;
                        else if (is_sw)  st <= S_IF;
                        else             st <= S_WB;
                    end else if (cnt == CNT_W'(MEM_WAIT_MAX)) begin
                        cnt     <= '0;
                        bus_err <= 1'b1;
                        st      <= S_HALT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ID: begin
                    if (is_jump)        st <= S_IF;
                    else if (!is_legal) begin
                        illegal <= 1'b1;
                        st      <= S_HALT;
                    end else            st <= S_EX;
                end
                S_EX: begin
                    if (is_beq)              st <= S_IF;
                    else if (is_lw || is_sw) st <= S_MEM;
                    else                     st <= S_WB;
                end
                S_WB:    st <= S_IF;
                default: st <= S_HALT;
            endcase
        end
    end

    assign state = st;

`ifdef MC_CTRL_PERF_EN
    // An instruction retires on any transition into IF from a later state.
    logic retire;
    always_comb retire = (st == S_ID && is_jump) || (st == S_EX && is_beq) ||
                         (st == S_MEM && mem_ack && is_sw) || (st == S_WB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (retire)              instr_cnt <= instr_cnt + 32'd1;
            if (mem_req && !mem_ack) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl.
// A reference model builds the expected state trace of each instruction
// from its latency and the memory wait it is given. It then derives the
// per-cycle enables from the instruction's control table.
module tb_mc_ctrl;
    localparam int WMAX = 15;

    localparam int C_ADDU = 0, C_SUBU = 1, C_JR = 2, C_ORI = 3, C_LUI = 4, C_LW = 5;
    localparam int C_SW = 6, C_BEQ = 7, C_J = 8, C_JAL = 9, C_BAD = 10, C_BADR = 11;

    logic       clk = 1'b0, reset = 1'b0, zero = 1'b0, mem_ack = 1'b0;
    logic [5:0] opcode = 6'h0, funct = 6'h0;
    logic       pc_we, ir_we, mem_req, mem_we, mem_ifetch, reg_we, alu_src_imm, ext_sign;
    logic       bus_err, illegal;
    logic [1:0] pc_src, reg_dst, wd_src;
    logic [2:0] alu_op, state;
`ifdef MC_CTRL_PERF_EN
    logic [31:0] instr_cnt, stall_cnt;
    int          m_ret = 0, m_stall = 0;
`endif

    int vectors = 0, fails = 0;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ack(mem_ack), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
        .mem_req(mem_req), .mem_we(mem_we), .mem_ifetch(mem_ifetch), .reg_we(reg_we),
        .reg_dst(reg_dst), .wd_src(wd_src), .alu_op(alu_op), .alu_src_imm(alu_src_imm),
        .ext_sign(ext_sign), .bus_err(bus_err), .illegal(illegal), .state(state)
`ifdef MC_CTRL_PERF_EN
        , .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [21:0] obs;
    always_comb obs = {pc_we, pc_src, ir_we, mem_req, mem_we, mem_ifetch, reg_we, reg_dst,
                       wd_src, alu_op, alu_src_imm, ext_sign, bus_err, illegal, state};

    function automatic void set_ir(input int c);
        case (c)
            C_ADDU:  begin opcode = 6'h00; funct = 6'h21; end
            C_SUBU:  begin opcode = 6'h00; funct = 6'h23; end
            C_JR:    begin opcode = 6'h00; funct = 6'h08; end
            C_ORI:   begin opcode = 6'h0D; funct = 6'h05; end
            C_LUI:   begin opcode = 6'h0F; funct = 6'h12; end
            C_LW:    begin opcode = 6'h23; funct = 6'h04; end
            C_SW:    begin opcode = 6'h2B; funct = 6'h08; end
            C_BEQ:   begin opcode = 6'h04; funct = 6'h21; end
            C_J:     begin opcode = 6'h02; funct = 6'h00; end
            C_JAL:   begin opcode = 6'h03; funct = 6'h00; end
            C_BAD:   begin opcode = 6'h3F; funct = 6'h00; end
            default: begin opcode = 6'h00; funct = 6'h20; end
        endcase
    endfunction

    // Control table for one cycle: enables per state and instruction.
    function automatic logic [21:0] model(input int s, input int c, input bit a, input bit z,
                                          input bit be, input bit il);
        logic pw = 0, iw = 0, mr = 0, mw = 0, mi = 0, rw = 0, asi = 0, es = 0;
        logic [1:0] ps = 0, rd = 0, ws = 0;
        logic [2:0] ao = 0;
        logic [2:0] sb = 3'(s);
        case (s)
            0: begin mr = 1; mi = 1; iw = a; pw = a; end
            1: case (c)
                C_J:   begin pw = 1; ps = 2; end
                C_JAL: begin pw = 1; ps = 2; rw = 1; rd = 2; ws = 2; end
                C_JR:  begin pw = 1; ps = 3; end
                default: ;
            endcase
            2: case (c)
                C_SUBU:     ao = 1;
                C_ORI:      begin ao = 2; asi = 1; end
                C_LUI:      begin ao = 3; asi = 1; end
                C_LW, C_SW: begin asi = 1; es = 1; end
                C_BEQ:      begin ao = 1; pw = z; ps = 1; end
                default: ;
            endcase
            3: begin mr = 1; mw = (c == C_SW); end
            4: begin rw = 1; rd = (c == C_ADDU || c == C_SUBU) ? 2'd1 : 2'd0;
                     ws = (c == C_LW) ? 2'd1 : 2'd0; end
            default: ;
        endcase
        return {pw, ps, iw, mr, mw, mi, rw, rd, ws, ao, asi, es, be, il, sb};
    endfunction

    task automatic apply_reset();
        reset = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
`ifdef MC_CTRL_PERF_EN
        m_ret = 0; m_stall = 0;
`endif
    endtask

    // Runs one instruction from IF, starting and ending at a falling edge.
    // A wait larger than WMAX means the request is never acked (timeout).
    task automatic run_instr(input int c, input bit z, input int if_wait, input int mem_wait,
                             output bit halted);
        int qs[$], qa[$];
        logic [21:0] exp;
        halted = 0;
        set_ir(c);
        zero = z;
        for (int i = 0; i < ((if_wait > WMAX) ? WMAX + 1 : if_wait); i++) begin
            qs.push_back(0); qa.push_back(0);
        end
        if (if_wait > WMAX) halted = 1;
        else begin
            qs.push_back(0); qa.push_back(1);
            qs.push_back(1); qa.push_back(int'($urandom_range(0, 1)));
            if (c == C_BAD || c == C_BADR) halted = 1;
            else if (c != C_J && c != C_JAL && c != C_JR) begin
                qs.push_back(2); qa.push_back(int'($urandom_range(0, 1)));
                if (c == C_LW || c == C_SW) begin
                    for (int i = 0; i < ((mem_wait > WMAX) ? WMAX + 1 : mem_wait); i++) begin
                        qs.push_back(3); qa.push_back(0);
                    end
                    if (mem_wait > WMAX) halted = 1;
                    else begin qs.push_back(3); qa.push_back(1); end
                end
                if (!halted && c != C_BEQ && c != C_SW) begin
                    qs.push_back(4); qa.push_back(int'($urandom_range(0, 1)));
                end
            end
        end
        for (int i = 0; i < qs.size(); i++) begin
            mem_ack = qa[i][0];
            #1;
            exp = model(qs[i], c, qa[i][0], z, 1'b0, 1'b0);
            vectors++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL instr%0d cyc%0d: got %h want %h", c, i, obs, exp);
            end
`ifdef MC_CTRL_PERF_EN
            vectors++;
            if (instr_cnt !== 32'(m_ret) || stall_cnt !== 32'(m_stall)) begin
                fails++;
                $display("FAIL perf cyc%0d: got %0d/%0d want %0d/%0d", i, instr_cnt,
                         stall_cnt, m_ret, m_stall);
            end
            if ((qs[i] == 0 || qs[i] == 3) && qa[i] == 0) m_stall++;
`endif
            @(negedge clk);
        end
`ifdef MC_CTRL_PERF_EN
        if (!halted) m_ret++;
`endif
    endtask

    task automatic check_halt(input int c, input bit be, input bit il);
        logic [21:0] exp;
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            #1;
            exp = model(7, c, mem_ack, zero, be, il);
            vectors++;
            if (obs !== exp) begin
                fails++;
                $display("FAIL halt%0d: got %h want %h", i, obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        set_ir(C_J);
        mem_ack = 1'b1;
        #1;
        vectors++;
        if (obs !== 22'h0) begin fails++; $display("FAIL reset_t0: got %h want 0", obs); end
        @(negedge clk);
        vectors++;
        if (obs !== 22'h0) begin fails++; $display("FAIL reset_hold: got %h want 0", obs); end
        reset = 1'b1;
        mem_ack = 1'b0;
        #1;
        vectors++;
        if (obs !== model(0, C_J, 0, 0, 0, 0)) begin
            fails++; $display("FAIL first_fetch: got %h want %h", obs, model(0, C_J, 0, 0, 0, 0));
        end
        @(negedge clk);
        apply_reset();
    endtask

    task automatic test_directed();
        bit h;
        run_instr(C_ORI, 0, 0, 0, h);   // 4 cycles
        run_instr(C_LW, 0, 0, 3, h);    // 8 cycles, MEM held 4
        run_instr(C_BEQ, 1, 0, 0, h);
        run_instr(C_BEQ, 0, 0, 0, h);
        run_instr(C_JAL, 0, 0, 0, h);
        run_instr(C_SW, 0, 2, 0, h);
        run_instr(C_ADDU, 0, WMAX, 0, h);  // ack in the limit cycle
        run_instr(C_LW, 0, 0, WMAX, h);
    endtask

    task automatic test_random();
        bit h;
        int c, wi, wm;
        for (int n = 0; n < 60; n++) begin
            c  = int'($urandom_range(0, 9));
            wi = ($urandom_range(0, 9) == 0) ? WMAX : int'($urandom_range(0, 4));
            wm = ($urandom_range(0, 9) == 0) ? WMAX : int'($urandom_range(0, 4));
            run_instr(c, 1'($urandom_range(0, 1)), wi, wm, h);
        end
    endtask

    task automatic test_bus_err();
        bit h;
        run_instr(C_ADDU, 0, WMAX + 1, 0, h);
        vectors++;
        if (h !== 1'b1) begin fails++; $display("FAIL fetch_timeout_model: got %0d want 1", h); end
        check_halt(C_ADDU, 1, 0);
        reset = 1'b0;
        #1;
        vectors++;
        if (obs !== 22'h0) begin fails++; $display("FAIL err_reset: got %h want 0", obs); end
        @(negedge clk);
        reset = 1'b1;
`ifdef MC_CTRL_PERF_EN
        m_ret = 0; m_stall = 0;
`endif
        run_instr(C_SW, 0, 0, WMAX + 1, h);
        check_halt(C_SW, 1, 0);
        apply_reset();
    endtask

    task automatic test_illegal();
        bit h;
        run_instr(C_BAD, 0, 1, 0, h);
        check_halt(C_BAD, 0, 1);
        apply_reset();
        run_instr(C_BADR, 0, 0, 0, h);
        check_halt(C_BADR, 0, 1);
        apply_reset();
    endtask

    task automatic test_reset_mid();
        set_ir(C_ADDU);
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);   // IF(ack) -> ID -> EX -> WB
        #1;
        vectors++;
        if (obs !== model(4, C_ADDU, 1, 0, 0, 0)) begin
            fails++; $display("FAIL mid_wb: got %h want %h", obs, model(4, C_ADDU, 1, 0, 0, 0));
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (obs !== 22'h0) begin fails++; $display("FAIL mid_abort: got %h want 0", obs); end
        @(negedge clk);
        reset = 1'b1;
`ifdef MC_CTRL_PERF_EN
        m_ret = 0; m_stall = 0;
`endif
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_bus_err();
        test_illegal();
        test_reset_mid();
        test_directed();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
